// File: rtl/qs_pkg.sv
// qs_pkg: shared widths, checker FSM states and the packed per-packet status record.
package qs_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned N     = 64;
    localparam int unsigned LEN_W = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             ord_err;
        logic             frm_err;
        logic             up_err;
        logic [W-1:0]     sum;
    } stat_t;

endpackage

// File: rtl/qs_chk_sat_cnt.sv
// qs_chk_sat_cnt: CW-bit counter that adds a small step when enabled and sticks at all-ones.
module qs_chk_sat_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    step,
    output logic [CW-1:0] cnt
);

    logic [CW:0] sum;

    // One guard bit is enough: step never exceeds 3, so any overflow lands in sum[CW].
    always_comb begin
        sum = {1'b0, cnt} + {{(CW - 1){1'b0}}, step};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sum[CW] ? '1 : sum[CW-1:0];
        end
    end

endmodule

// File: rtl/qs_chk.sv
// qs_chk: checks sorted packets for order, framing and length; one status pulse per packet.
// Optional: define QS_CHK_SUM_EN to accumulate a modulo-2^W data sum per packet.
module qs_chk #(
    parameter int unsigned W = qs_pkg::W,
    parameter int unsigned N = qs_pkg::N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic                   in_err,
    input  logic [W-1:0]           in_dat,
    output logic                   stat_vld_r,
    output logic [$clog2(N+1)-1:0] stat_len_r,
    output logic                   stat_ord_err_r,
    output logic                   stat_frm_err_r,
    output logic                   stat_up_err_r,
    output logic [W-1:0]           stat_sum_r,
    output logic [15:0]            cnt_pkt_r,
    output logic [15:0]            cnt_err_r
);

    import qs_pkg::*;

    localparam int unsigned      LW      = $clog2(N + 1);
    localparam logic [LW-1:0]    LEN_MAX = LW'(N);

    state_t       state, state_nxt;
    stat_t        acc, acc_nxt;
    stat_t        stat_q, stat_nxt;
    stat_t        first;
    stat_t        upd;
    logic [W-1:0] prev, prev_nxt;
    logic [W-1:0] sum_dat;
    logic         emit;
    logic         discard;
    logic         err_any;
    logic [1:0]   err_step;

`ifdef QS_CHK_SUM_EN
    assign sum_dat = in_dat;
`else
    assign sum_dat = '0;
`endif

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        prev_nxt  = prev;
        stat_nxt  = stat_q;
        emit      = 1'b0;
        discard   = 1'b0;

        first         = '0;
        first.len     = LW'(1);
        first.up_err  = in_err;
        first.sum     = sum_dat;

        // Continuation beat folded into the running packet record.
        upd         = acc;
        upd.len     = (acc.len == LEN_MAX) ? LEN_MAX : acc.len + LW'(1);
        upd.frm_err = acc.frm_err | (acc.len == LEN_MAX);
        upd.ord_err = acc.ord_err | (in_dat < prev);
        upd.up_err  = acc.up_err | in_err;
        upd.sum     = acc.sum + sum_dat;

        if (in_vld) begin
            case (state)
                IDLE: begin
                    if (in_sop && in_eop) begin
                        stat_nxt = first;
                        emit     = 1'b1;
                    end else if (in_sop) begin
                        acc_nxt   = first;
                        prev_nxt  = in_dat;
                        state_nxt = PKT;
                    end else begin
                        stat_nxt         = first;
                        stat_nxt.len     = '0;
                        stat_nxt.frm_err = 1'b1;
                        emit             = 1'b1;
                    end
                end
                PKT: begin
                    if (in_sop) begin
                        // Abort: report the old packet, the sop beat opens a new one.
                        stat_nxt         = acc;
                        stat_nxt.frm_err = 1'b1;
                        emit             = 1'b1;
                        if (in_eop) begin
                            discard   = 1'b1;
                            acc_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            acc_nxt  = first;
                            prev_nxt = in_dat;
                        end
                    end else begin
                        prev_nxt = in_dat;
                        if (in_eop) begin
                            stat_nxt  = upd;
                            emit      = 1'b1;
                            acc_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            acc_nxt = upd;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        err_any  = emit & (stat_nxt.ord_err | stat_nxt.frm_err | stat_nxt.up_err);
        err_step = {1'b0, err_any} + {1'b0, discard};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            prev       <= '0;
            stat_q     <= '0;
            stat_vld_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            prev       <= prev_nxt;
            stat_q     <= stat_nxt;
            stat_vld_r <= emit;
        end
    end

    // Without QS_CHK_SUM_EN the sum field is constant zero end to end.
    assign stat_len_r     = stat_q.len;
    assign stat_ord_err_r = stat_q.ord_err;
    assign stat_frm_err_r = stat_q.frm_err;
    assign stat_up_err_r  = stat_q.up_err;
    assign stat_sum_r     = stat_q.sum;

    qs_chk_sat_cnt #(.CW(16)) u_cnt_pkt (
        .clk  (clk),
        .rst  (rst),
        .en   (emit),
        .step (2'd1),
        .cnt  (cnt_pkt_r)
    );

    qs_chk_sat_cnt #(.CW(16)) u_cnt_err (
        .clk  (clk),
        .rst  (rst),
        .en   (|err_step),
        .step (err_step),
        .cnt  (cnt_err_r)
    );

endmodule

// File: doc/qs_chk.md
# qs_chk

Sorted-stream receiver/checker for the quicksort engine. Consumes the engine's sorted output stream (valid, start-of-packet, end-of-packet, error and data, no backpressure) and checks every packet for ascending order, framing and length. Reports a one-cycle status per packet and keeps saturating packet and error counters. Sits downstream of `qs` in benches and integration builds.

## Interface
- `W`, 32, data width; equals `qs_pkg::W`.
- `N`, 64, maximum legal packet length in beats.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_vld`  in  1  beat valid; always accepted, no ready.
- `in_sop`  in  1  first beat of packet.
- `in_eop`  in  1  last beat of packet.
- `in_err`  in  1  upstream error flag for the beat.
- `in_dat`  in  W  beat data, unsigned.
- `stat_vld_r`  out  1  one-cycle pulse; packet status valid.
- `stat_len_r`  out  $clog2(N+1)  beats received, saturating at N.
- `stat_ord_err_r`  out  1  non-ascending beat seen in packet.
- `stat_frm_err_r`  out  1  framing or length violation.
- `stat_up_err_r`  out  1  any beat of the packet had `in_err`.
- `stat_sum_r`  out  W  modulo-2^W sum of packet data (see Configuration).
- `cnt_pkt_r`  out  16  statuses emitted, saturating at 0xFFFF.
- `cnt_err_r`  out  16  statuses with any error bit set, plus discarded packets; saturating.

## Operation
- FSM states: IDLE, PKT. Reset state IDLE.
- IDLE, `in_vld & in_sop & in_eop`: single-beat packet; status len=1, remain IDLE.
- IDLE, `in_vld & in_sop & !in_eop`: capture beat as prev, len=1, go PKT.
- IDLE, `in_vld & !in_sop`: stray beat; status len=0, frm_err=1; remain IDLE.
- PKT, `in_vld & !in_sop`: len+1 (saturating at N). If the beat would make len exceed N, set frm_err. If `in_dat < prev` (unsigned), set ord_err. Update prev. On `in_eop`, emit status and go IDLE.
- PKT, `in_vld & in_sop`: abort; emit status for the old packet with frm_err=1 and its current len. The beat starts a new packet (len=1, PKT). If the beat also has `in_eop`, the new packet is discarded: no status, `cnt_err_r`+1, go IDLE.
- Equal adjacent values are legal (non-strict ascending).
- `up_err` is ORed across all beats of the packet, including sop and eop.
- Per-packet accumulators clear when a status is emitted.
- Counters saturate; there is no wrap.

## Timing
- Status registered: `stat_vld_r` rises the cycle after the eop, abort or stray beat and stays high for exactly one cycle.
- Status fields hold their value until the next status; they reset to 0.
- Counters update in the same cycle `stat_vld_r` asserts; a discard updates `cnt_err_r` the cycle after the beat.
- Beats may arrive back-to-back every cycle, and at most one status is produced per cycle.
- All outputs are 0 at reset. Reset mid-packet drops the packet silently, with no status.
- Cycles with `in_vld=0` are ignored in every state; gaps inside a packet are legal.

## Configuration
- `QS_CHK_SUM_EN` defined: a W-bit modulo accumulator of `in_dat` per packet drives `stat_sum_r`, for comparison against the sum taken on the producer side.
- Not defined: no accumulator; `stat_sum_r` is tied to 0.

## Structure
- `qs_pkg` holds `W`, `N`, `LEN_W = $clog2(N+1)`, the FSM state enum, and the packed status struct typedef (len, ord_err, frm_err, up_err, sum).
- Sub-module `qs_chk_sat_cnt` (parameterised-width saturating counter with increment enable) is instantiated twice, for `cnt_pkt_r` and `cnt_err_r`.

## Test plan
- Packet 3,5,5,9 back-to-back -> one status, len=4, all errors 0, sum=22, `cnt_pkt_r`=1, `cnt_err_r`=0.
- Packet 4,2,7 -> status len=3, ord_err=1, `cnt_err_r`=1.
- Stray beat in IDLE, then sop 1 / eop 2 -> first status len=0 frm_err=1; second status len=2 clean.
- sop 1, 2, then sop 8, eop 9 -> status len=2 frm_err=1, then status len=2 clean. Repeat with the second sop beat carrying eop -> only the abort status appears and `cnt_err_r` increments twice.
- N+2 beats with eop on the last -> len=N, frm_err=1. Packet with `in_err` on its middle beat -> up_err=1.
- Assert `rst` mid-packet, then send a 2-beat packet -> all outputs 0 during reset, then a single clean status len=2. Force counters to 0xFFFF -> further packets do not wrap.
